// File: rtl/cpu_mc_wait_pkg.sv
// Shared types and instruction field positions for the multicycle 16-bit core.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_MOV  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_CMP  = 4'd3,
        OP_LD   = 4'd4,
        OP_ST   = 4'd5,
        OP_MVHI = 4'd6,
        OP_J    = 4'd8,
        OP_JZ   = 4'd9,
        OP_JN   = 4'd10,
        OP_CALL = 4'd12
    } opcode_e;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        LDWB,
        HALT
    } state_e;

    localparam int unsigned OP_LSB    = 0;
    localparam int unsigned OP_MSB    = 3;
    localparam int unsigned IMM_BIT   = 4;
    localparam int unsigned RX_LSB    = 5;
    localparam int unsigned RX_MSB    = 7;
    localparam int unsigned RY_LSB    = 8;
    localparam int unsigned RY_MSB    = 10;
    localparam int unsigned IMM8_LSB  = 8;
    localparam int unsigned IMM8_MSB  = 15;
    localparam int unsigned IMM11_LSB = 5;
    localparam int unsigned IMM11_MSB = 15;

    // Sign-extend the 8-bit immediate to a 16-bit operand.
    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

    // Sign-extend the 11-bit jump offset and scale it to a byte offset.
    function automatic logic [15:0] jofs11(input logic [10:0] v);
        return {{4{v[10]}}, v, 1'b0};
    endfunction

endpackage

// File: rtl/cpu_mc_wait_gprs.sv
// 8 x 16 general-purpose register file: two asynchronous read ports, one write port.
module gprs_top (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  raddr_a,
    output logic [15:0] rdata_a,
    input  logic [2:0]  raddr_b,
    output logic [15:0] rdata_b,
    input  logic        we,
    input  logic [2:0]  waddr,
    input  logic [15:0] wdata
);

    logic [15:0] regs [8];

    // Registers clear on reset; one write per cycle when we is set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/cpu_mc_wait.sv
// Multicycle 16-bit core with waitrequest handshake, halt control and retire counter.
module cpu_mc_wait
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W   = 16,
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned RET_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_rd,
    output logic              o_mem_wr,
    output logic [15:0]       o_mem_wrdata,
    input  logic              i_mem_waitrequest,
    input  logic [15:0]       i_mem_rddata,
    input  logic              i_halt,
    output logic              o_halted,
    output logic [ADDR_W-1:0] o_pc,
    output logic [RET_W-1:0]  o_retired
);

    state_e      state;
    logic [15:0] ir;
    logic        flag_n;
    logic        flag_z;

    opcode_e     op;
    opcode_e     dec_op;
    logic        dec_ldst;
    logic [2:0]  rx_sel;
    logic [2:0]  ry_sel;
    logic [15:0] ra_data;
    logic [15:0] rb_data;
    logic [15:0] op_b;
    logic [15:0] sum;
    logic [15:0] diff;
    logic [15:0] alu_res;
    logic        set_flags;
    logic        taken;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_after;
    logic [ADDR_W-1:0] next_fetch;
    logic        retire;

    logic        gpr_we;
    logic [2:0]  gpr_waddr;
    logic [15:0] gpr_wdata;

    // While decoding, register reads follow the word arriving from memory so that
    // ld/st can present their address straight from DECODE; this keeps ld/st
    // latency at 4/3 cycles while all outputs stay registered.
    assign rx_sel   = (state == DECODE) ? i_mem_rddata[RX_MSB:RX_LSB] : ir[RX_MSB:RX_LSB];
    assign ry_sel   = (state == DECODE) ? i_mem_rddata[RY_MSB:RY_LSB] : ir[RY_MSB:RY_LSB];
    assign op       = opcode_e'(ir[OP_MSB:OP_LSB]);
    assign dec_op   = opcode_e'(i_mem_rddata[OP_MSB:OP_LSB]);
    assign dec_ldst = (dec_op == OP_LD) || (dec_op == OP_ST);

    gprs_top u_gprs (
        .clk     (clk),
        .reset   (reset),
        .raddr_a (rx_sel),
        .rdata_a (ra_data),
        .raddr_b (ry_sel),
        .rdata_b (rb_data),
        .we      (gpr_we),
        .waddr   (gpr_waddr),
        .wdata   (gpr_wdata)
    );

    assign op_b = ir[IMM_BIT] ? sext8(ir[IMM8_MSB:IMM8_LSB]) : rb_data;
    assign sum  = ra_data + op_b;
    assign diff = ra_data - op_b;

    // In EXEC o_pc already holds pc_next, so relative jumps are based on it.
    assign target   = ir[IMM_BIT] ? ADDR_W'(16'(o_pc) + jofs11(ir[IMM11_MSB:IMM11_LSB]))
                                  : ra_data[ADDR_W-1:0];
    assign pc_after = taken ? target : o_pc;

    assign retire     = (state == EXEC) || (state == LDWB) ||
                        ((state == MEM) && !i_mem_waitrequest && (op == OP_ST));
    assign next_fetch = (state == EXEC) ? pc_after : o_pc;

    // ALU, branch resolution and register writeback select.
    always_comb begin
        gpr_we    = 1'b0;
        gpr_waddr = ir[RX_MSB:RX_LSB];
        gpr_wdata = '0;
        alu_res   = '0;
        set_flags = 1'b0;
        taken     = 1'b0;
        case (state)
            EXEC: begin
                case (op)
                    OP_MOV: begin
                        gpr_we    = 1'b1;
                        gpr_wdata = op_b;
                    end
                    OP_ADD: begin
                        alu_res   = sum;
                        set_flags = 1'b1;
                        gpr_we    = 1'b1;
                        gpr_wdata = sum;
                    end
                    OP_SUB: begin
                        alu_res   = diff;
                        set_flags = 1'b1;
                        gpr_we    = 1'b1;
                        gpr_wdata = diff;
                    end
                    OP_CMP: begin
                        alu_res   = diff;
                        set_flags = 1'b1;
                    end
                    OP_MVHI: begin
                        gpr_we    = 1'b1;
                        gpr_wdata = {ir[IMM8_MSB:IMM8_LSB], ra_data[7:0]};
                    end
                    OP_J:  taken = 1'b1;
                    OP_JZ: taken = flag_z;
                    OP_JN: taken = flag_n;
                    OP_CALL: begin
                        taken     = 1'b1;
                        gpr_we    = 1'b1;
                        gpr_waddr = 3'd7;
                        gpr_wdata = 16'(o_pc);
                    end
                    default: ;
                endcase
            end
            LDWB: begin
                gpr_we    = 1'b1;
                gpr_wdata = i_mem_rddata;
            end
            default: ;
        endcase
    end

    // Control FSM with registered bus outputs, PC, flags and retire counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= FETCH;
            o_pc         <= RESET_PC[ADDR_W-1:0];
            ir           <= '0;
            flag_n       <= 1'b0;
            flag_z       <= 1'b0;
            o_mem_rd     <= 1'b0;
            o_mem_wr     <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_wrdata <= '0;
            o_retired    <= '0;
            o_halted     <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    // Only the first fetch after reset finds rd low; every other
                    // entry into FETCH already has the request on the bus.
                    if (!o_mem_rd) begin
                        o_mem_rd   <= 1'b1;
                        o_mem_addr <= o_pc;
                    end else if (!i_mem_waitrequest) begin
                        o_mem_rd <= 1'b0;
                        state    <= DECODE;
                    end
                end
                DECODE: begin
                    ir   <= i_mem_rddata;
                    o_pc <= o_pc + ADDR_W'(2);
                    if (dec_ldst) begin
                        state        <= MEM;
                        o_mem_addr   <= {rb_data[ADDR_W-1:1], 1'b0};
                        o_mem_rd     <= (dec_op == OP_LD);
                        o_mem_wr     <= (dec_op == OP_ST);
                        if (dec_op == OP_ST) begin
                            o_mem_wrdata <= ra_data;
                        end
                    end else begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (set_flags) begin
                        flag_n <= alu_res[15];
                        flag_z <= (alu_res == '0);
                    end
                    o_pc <= pc_after;
                end
                MEM: begin
                    if (!i_mem_waitrequest) begin
                        o_mem_rd <= 1'b0;
                        o_mem_wr <= 1'b0;
                        if (op != OP_ST) begin
                            state <= LDWB;
                        end
                    end
                end
                LDWB: ;
                HALT: begin
                    if (!i_halt) begin
                        o_halted   <= 1'b0;
                        state      <= FETCH;
                        o_mem_rd   <= 1'b1;
                        o_mem_addr <= o_pc;
                    end
                end
                default: state <= FETCH;
            endcase

            if (retire) begin
                o_retired <= o_retired + RET_W'(1);
                if (i_halt) begin
                    state    <= HALT;
                    o_halted <= 1'b1;
                end else begin
                    state      <= FETCH;
                    o_mem_rd   <= 1'b1;
                    o_mem_addr <= next_fetch;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_mc_wait.sv
// Bench for cpu_mc_wait: table of straight-line instructions plus wait, halt and reset sequences.
module tb_cpu_mc_wait;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] o_mem_addr;
    logic        o_mem_rd;
    logic        o_mem_wr;
    logic [15:0] o_mem_wrdata;
    logic        i_mem_waitrequest;
    logic [15:0] i_mem_rddata;
    logic        i_halt;
    logic        o_halted;
    logic [15:0] o_pc;
    logic [31:0] o_retired;

    cpu_mc_wait #(
        .ADDR_W   (16),
        .RESET_PC (16'h0000),
        .RET_W    (32)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .o_mem_addr        (o_mem_addr),
        .o_mem_rd          (o_mem_rd),
        .o_mem_wr          (o_mem_wr),
        .o_mem_wrdata      (o_mem_wrdata),
        .i_mem_waitrequest (i_mem_waitrequest),
        .i_mem_rddata      (i_mem_rddata),
        .i_halt            (i_halt),
        .o_halted          (o_halted),
        .o_pc              (o_pc),
        .o_retired         (o_retired)
    );

    always #5 clk = ~clk;

    // Memory: program below 0x100, data at 0x100+; data accesses see data_waits wait cycles.
    logic [15:0] rom [128];
    logic [15:0] ram [128];
    int unsigned data_waits = 0;
    int unsigned wcnt;
    logic        mem_req;
    logic        data_sel;

    assign mem_req           = o_mem_rd | o_mem_wr;
    assign data_sel          = (o_mem_addr[15:8] != 8'h00);
    assign i_mem_waitrequest = mem_req && data_sel && (wcnt != 0);

    // Memory model: fixed read latency 1, write on accept.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt <= data_waits;
        end else if (mem_req) begin
            if (i_mem_waitrequest) begin
                wcnt <= wcnt - 1;
            end else begin
                wcnt <= data_waits;
                if (o_mem_rd) begin
                    i_mem_rddata <= data_sel ? ram[o_mem_addr[7:1]] : rom[o_mem_addr[7:1]];
                end else if (data_sel) begin
                    ram[o_mem_addr[7:1]] <= o_mem_wrdata;
                end
            end
        end
    end

    // Bus monitor: request held stable under waitrequest, rd/wr exclusive.
    logic        prev_wait;
    logic [33:0] prev_bus;
    int unsigned stab_err = 0;
    int unsigned stab_seen = 0;
    int unsigned excl_err = 0;
    always @(negedge clk) begin
        if (reset) begin
            prev_wait <= 1'b0;
        end else begin
            if (prev_wait) begin
                stab_seen <= stab_seen + 1;
                if ({o_mem_rd, o_mem_wr, o_mem_addr, o_mem_wrdata} != prev_bus)
                    stab_err <= stab_err + 1;
            end
            if (o_mem_rd && o_mem_wr) excl_err <= excl_err + 1;
            prev_wait <= i_mem_waitrequest;
            prev_bus  <= {o_mem_rd, o_mem_wr, o_mem_addr, o_mem_wrdata};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic run_one(output int unsigned cyc);
        logic [31:0] r0;
        r0  = o_retired;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (o_retired == r0 && cyc < 100);
    endtask

    function automatic logic [15:0] gpr(input logic [2:0] i);
        return dut.u_gprs.regs[i];
    endfunction

    function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rx, input logic [7:0] imm);
        return {imm, rx, 1'b1, op};
    endfunction
    function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rx, input logic [2:0] ry);
        return {5'b0, ry, rx, 1'b0, op};
    endfunction
    function automatic logic [15:0] enc_j(input logic [3:0] op, input logic [10:0] off);
        return {off, 1'b1, op};
    endfunction
    function automatic logic [15:0] enc_jr(input logic [3:0] op, input logic [2:0] rx);
        return {8'b0, rx, 1'b0, op};
    endfunction

    typedef struct {
        logic [15:0] addr;
        logic [15:0] instr;
        logic [2:0]  rsel;
        logic [15:0] rval;
        logic        n;
        logic        z;
        logic [15:0] pc;
        int unsigned cyc;
    } vec_t;

    vec_t        vt [19];
    int unsigned cyc;
    logic [31:0] r0;
    logic        found;

    initial begin
        //          addr      instr                      reg   value     n     z     next pc  cycles
        vt[0]  = '{16'h0002, enc_i(4'd0, 3'd1, 8'h05),  3'd1, 16'h0005, 1'b0, 1'b0, 16'h0004, 3};
        vt[1]  = '{16'h0004, enc_i(4'd1, 3'd1, 8'hFA),  3'd1, 16'hFFFF, 1'b1, 1'b0, 16'h0006, 3};
        vt[2]  = '{16'h0006, enc_i(4'd0, 3'd2, 8'h34),  3'd2, 16'h0034, 1'b1, 1'b0, 16'h0008, 3};
        vt[3]  = '{16'h0008, enc_i(4'd6, 3'd2, 8'hAB),  3'd2, 16'hAB34, 1'b1, 1'b0, 16'h000A, 3};
        vt[4]  = '{16'h000A, enc_i(4'd0, 3'd3, 8'h01),  3'd3, 16'h0001, 1'b1, 1'b0, 16'h000C, 3};
        vt[5]  = '{16'h000C, enc_i(4'd6, 3'd3, 8'h01),  3'd3, 16'h0101, 1'b1, 1'b0, 16'h000E, 3};
        vt[6]  = '{16'h000E, enc_r(4'd5, 3'd1, 3'd3),   3'd1, 16'hFFFF, 1'b1, 1'b0, 16'h0010, 3};
        vt[7]  = '{16'h0010, enc_r(4'd4, 3'd4, 3'd3),   3'd4, 16'hFFFF, 1'b1, 1'b0, 16'h0012, 4};
        vt[8]  = '{16'h0012, enc_r(4'd2, 3'd4, 3'd2),   3'd4, 16'h54CB, 1'b0, 1'b0, 16'h0014, 3};
        vt[9]  = '{16'h0014, enc_r(4'd3, 3'd0, 3'd0),   3'd0, 16'h0000, 1'b0, 1'b1, 16'h0016, 3};
        vt[10] = '{16'h0016, enc_j(4'd9, 11'd1),        3'd5, 16'h0000, 1'b0, 1'b1, 16'h001A, 3};
        vt[11] = '{16'h001A, enc_j(4'd10, 11'd5),       3'd5, 16'h0000, 1'b0, 1'b1, 16'h001C, 3};
        vt[12] = '{16'h001C, enc_i(4'd0, 3'd5, 8'h40),  3'd5, 16'h0040, 1'b0, 1'b1, 16'h001E, 3};
        vt[13] = '{16'h001E, enc_i(4'd0, 3'd6, 8'hFF),  3'd6, 16'hFFFF, 1'b0, 1'b1, 16'h0020, 3};
        vt[14] = '{16'h0020, enc_jr(4'd12, 3'd5),       3'd7, 16'h0022, 1'b0, 1'b1, 16'h0040, 3};
        vt[15] = '{16'h0040, enc_j(4'd8, 11'd3),        3'd7, 16'h0022, 1'b0, 1'b1, 16'h0048, 3};
        vt[16] = '{16'h0048, enc_j(4'd9, 11'h7FD),      3'd7, 16'h0022, 1'b0, 1'b1, 16'h0044, 3};
        vt[17] = '{16'h0044, enc_jr(4'd8, 3'd7),        3'd7, 16'h0022, 1'b0, 1'b1, 16'h0022, 3};
        vt[18] = '{16'h0022, 16'h000B,                  3'd6, 16'hFFFF, 1'b0, 1'b1, 16'h0024, 3};

        for (int i = 0; i < 128; i++) rom[i] = 16'h0007;
        for (int i = 0; i < 19; i++) rom[vt[i].addr[7:1]] = vt[i].instr;
        rom[8'h0C] = enc_i(4'd0, 3'd5, 8'h77);   // 0x18: skipped by the jz
        rom[8'h12] = enc_r(4'd5, 3'd2, 3'd3);    // 0x24: st r2,[r3]
        rom[8'h13] = enc_r(4'd4, 3'd4, 3'd3);    // 0x26: ld r4,[r3]
        rom[8'h14] = enc_r(4'd4, 3'd5, 3'd3);    // 0x28: ld r5,[r3]
        rom[8'h15] = enc_r(4'd5, 3'd1, 3'd3);    // 0x2A: st r1,[r3]

        reset  = 1'b1;
        i_halt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd", o_mem_rd, 1'b0);
        chk("rst_wr", o_mem_wr, 1'b0);
        chk("rst_addr", o_mem_addr, 16'h0000);
        chk("rst_wrdata", o_mem_wrdata, 16'h0000);
        chk("rst_retired", o_retired, 32'd0);
        chk("rst_halted", o_halted, 1'b0);
        chk("rst_pc", o_pc, 16'h0000);
        reset = 1'b0;

        // Undefined opcode at 0x00 retires as a nop.
        run_one(cyc);
        chk("nop_cycles", cyc, 4);
        chk("nop_retired", o_retired, 32'd1);
        chk("nop_pc", o_pc, 16'h0002);

        for (int i = 0; i < 19; i++) begin
            run_one(cyc);
            chk($sformatf("v%0d_cycles", i), cyc, vt[i].cyc);
            chk($sformatf("v%0d_reg", i), gpr(vt[i].rsel), vt[i].rval);
            chk($sformatf("v%0d_n", i), dut.flag_n, vt[i].n);
            chk($sformatf("v%0d_z", i), dut.flag_z, vt[i].z);
            chk($sformatf("v%0d_pc", i), o_pc, vt[i].pc);
            if (i == 1) chk("retired_after_add", o_retired, 32'd3);
        end

        // Store then load with three wait cycles on each data access.
        data_waits = 3;
        run_one(cyc);
        chk("st_wait_cycles", cyc, 6);
        chk("st_wait_mem", ram[0], 16'hAB34);
        run_one(cyc);
        chk("ld_wait_cycles", cyc, 7);
        chk("ld_wait_r4", gpr(3'd4), 16'hAB34);

        // Halt requested while a ld is in its memory phase.
        data_waits = 0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #1;
            if (o_mem_rd && o_mem_addr[15:8] != 8'h00) found = 1'b1;
        end
        chk("halt_ld_mem_seen", found, 1'b1);
        i_halt = 1'b1;
        r0 = o_retired;
        repeat (2) @(posedge clk);
        #1;
        chk("halt_halted", o_halted, 1'b1);
        chk("halt_ld_retired", o_retired, r0 + 32'd1);
        chk("halt_ld_r5", gpr(3'd5), 16'hAB34);
        chk("halt_pc", o_pc, 16'h002A);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("halt_idle%0d", i), {29'd0, o_mem_rd, o_mem_wr, o_halted}, 32'd1);
        end
        i_halt = 1'b0;
        @(posedge clk);
        #1;
        chk("resume_halted", o_halted, 1'b0);
        chk("resume_rd", o_mem_rd, 1'b1);
        chk("resume_addr", o_mem_addr, 16'h002A);

        // Reset while a store waits: request dropped, no write lands.
        data_waits = 5;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #1;
            if (o_mem_wr) found = 1'b1;
        end
        chk("rst_st_seen", found, 1'b1);
        @(posedge clk);
        #1;
        chk("rst_st_held", o_mem_wr, 1'b1);
        reset = 1'b1;
        #1;
        chk("rstmid_wr", o_mem_wr, 1'b0);
        chk("rstmid_rd", o_mem_rd, 1'b0);
        chk("rstmid_pc", o_pc, 16'h0000);
        chk("rstmid_retired", o_retired, 32'd0);
        chk("rstmid_halted", o_halted, 1'b0);
        chk("rstmid_addr", o_mem_addr, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rstmid_mem_kept", ram[0], 16'hAB34);
        chk("rstmid_r1_clear", gpr(3'd1), 16'h0000);
        @(posedge clk);
        #1;
        chk("rst_refetch_rd", o_mem_rd, 1'b1);
        chk("rst_refetch_addr", o_mem_addr, 16'h0000);

        repeat (2) @(posedge clk);
        #1;
        chk("bus_stable_err", stab_err, 32'd0);
        chk("wait_cycles_seen", {31'd0, stab_seen >= 6}, 32'd1);
        chk("rd_wr_exclusive_err", excl_err, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
